// File: rtl/cache_pkg.sv
// Shared definitions for the cache line transfer controller: state encoding
// and the ceiling-log2 helper used to derive counter and address field widths.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVICT = 2'd1,
        ST_FILL  = 2'd2
    } cache_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_line_transfer_fsm_if.sv
// Memory request port between the cache miss handler (master) and memory (slave).
interface cache_line_transfer_fsm_if #(
    parameter int ADDR_WIDTH = 16
) ();

    logic                  mem_req_valid;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_rdata_valid;

    modport master (
        output mem_req_valid, mem_req_write, mem_req_addr,
        input  mem_req_ready, mem_rdata_valid
    );

    modport slave (
        input  mem_req_valid, mem_req_write, mem_req_addr,
        output mem_req_ready, mem_rdata_valid
    );

endinterface

// File: rtl/cache_word_counter.sv
// Word index counter with synchronous clear and a sticky flag that records the
// increment past the last index, so a full pass is distinguishable from index 0.
module cache_word_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (enable) begin
            count <= count + 1'b1;
            if (&count) wrap <= 1'b1;
        end
    end

endmodule

// File: rtl/cache_line_transfer_fsm.sv
// Cache miss handler: optional write-back of a dirty victim line, then a
// pipelined line fill with a bounded number of outstanding reads.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a miss; addresses captured on miss_detected
//   ST_EVICT | writing victim words 0..N-1 back to memory
//   ST_FILL  | issuing fill reads and writing returned words into the array
module cache_line_transfer_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORD_BYTES      = 2,
    parameter int WORDS_PER_LINE  = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              miss_detected,
    input  logic [ADDR_WIDTH-1:0]             miss_address,
    input  logic                              victim_dirty,
    input  logic [ADDR_WIDTH-1:0]             victim_address,
    output logic                              fsm_busy,
    cache_line_transfer_fsm_if.master         mem,
    output logic [clog2(WORDS_PER_LINE)-1:0]  data_word_sel,
    output logic                              write_data_array,
    output logic                              write_tag_array
);

    localparam int WB   = clog2(WORD_BYTES);
    localparam int WI   = clog2(WORDS_PER_LINE);
    localparam int OFF  = WB + WI;
    localparam int LINE = ADDR_WIDTH - OFF;
    localparam int OW   = clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] MAX_OUT  = OW'(MAX_OUTSTANDING);
    localparam logic [WI-1:0] LAST_IDX = WI'(WORDS_PER_LINE - 1);

    cache_state_t state, state_nxt;

    logic [LINE-1:0]       fill_line, evict_line;
    logic [OW-1:0]         outstanding;
    logic [WI-1:0]         req_idx, ret_idx;
    logic                  req_done, ret_wrap;
    logic                  req_clear, req_en, ret_clear, ret_en;
    logic                  capture, issue, fill_valid, ret_ok;
    logic [ADDR_WIDTH-1:0] fill_addr, evict_addr;
    logic                  unused_bits;

    // wb_idx and req_idx share one counter; EVICT and FILL never overlap.
    cache_word_counter #(.WIDTH(WI)) u_req_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (req_clear),
        .enable (req_en),
        .count  (req_idx),
        .wrap   (req_done)
    );

    cache_word_counter #(.WIDTH(WI)) u_ret_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (ret_clear),
        .enable (ret_en),
        .count  (ret_idx),
        .wrap   (ret_wrap)
    );

    assign unused_bits = ^{miss_address[OFF-1:0], victim_address[OFF-1:0], ret_wrap};

    assign fill_addr  = (ADDR_WIDTH'(fill_line)  << OFF) | (ADDR_WIDTH'(req_idx) << WB);
    assign evict_addr = (ADDR_WIDTH'(evict_line) << OFF) | (ADDR_WIDTH'(req_idx) << WB);
    assign fsm_busy   = (state != ST_IDLE);
    // A return with nothing in flight is a protocol error and is dropped.
    assign ret_ok     = (state == ST_FILL) && mem.mem_rdata_valid && (outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fill_line  <= '0;
            evict_line <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                fill_line  <= miss_address[ADDR_WIDTH-1:OFF];
                evict_line <= victim_address[ADDR_WIDTH-1:OFF];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (ret_clear) begin
            outstanding <= '0;
        end else begin
            case ({issue, ret_en})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_comb begin
        state_nxt            = state;
        mem.mem_req_valid    = 1'b0;
        mem.mem_req_write    = 1'b0;
        mem.mem_req_addr     = '0;
        data_word_sel        = '0;
        write_data_array     = 1'b0;
        write_tag_array      = 1'b0;
        req_clear            = 1'b0;
        req_en               = 1'b0;
        ret_clear            = 1'b0;
        ret_en               = 1'b0;
        capture              = 1'b0;
        issue                = 1'b0;
        fill_valid           = 1'b0;

        case (state)
            ST_IDLE: begin
                if (miss_detected) begin
                    capture   = 1'b1;
                    state_nxt = victim_dirty ? ST_EVICT : ST_FILL;
                end
            end
            ST_EVICT: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_write = 1'b1;
                mem.mem_req_addr  = evict_addr;
                data_word_sel     = req_idx;
                if (mem.mem_req_ready) begin
                    req_en = 1'b1;
                    if (req_idx == LAST_IDX) begin
                        req_clear = 1'b1;
                        state_nxt = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                fill_valid        = !req_done && (outstanding < MAX_OUT);
                mem.mem_req_valid = fill_valid;
                mem.mem_req_addr  = fill_addr;
                data_word_sel     = ret_idx;
                if (fill_valid && mem.mem_req_ready) begin
                    req_en = 1'b1;
                    issue  = 1'b1;
                end
                if (ret_ok) begin
                    write_data_array = 1'b1;
                    ret_en           = 1'b1;
                    if (ret_idx == LAST_IDX) begin
                        write_tag_array = 1'b1;
                        req_clear       = 1'b1;
                        ret_clear       = 1'b1;
                        state_nxt       = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_line_transfer_fsm.sv
// Scoreboard bench for cache_line_transfer_fsm: a default-parameter instance and a
// 32-bit / 4-byte-word / 4-word-line / 2-outstanding instance share one memory model.
module tb_cache_line_transfer_fsm;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic        use_b          = 1'b0;
    logic        miss_detected  = 1'b0;
    logic        victim_dirty   = 1'b0;
    logic [31:0] miss_address   = '0;
    logic [31:0] victim_address = '0;
    logic        ready          = 1'b0;
    logic        rdata_valid    = 1'b0;

    cache_line_transfer_fsm_if #(.ADDR_WIDTH(16)) ifa ();
    cache_line_transfer_fsm_if #(.ADDR_WIDTH(32)) ifb ();

    logic       busy_a, busy_b, wda_a, wda_b, tag_a, tag_b;
    logic [2:0] sel_a;
    logic [1:0] sel_b;

    assign ifa.mem_req_ready   = ready & ~use_b;
    assign ifb.mem_req_ready   = ready & use_b;
    assign ifa.mem_rdata_valid = rdata_valid & ~use_b;
    assign ifb.mem_rdata_valid = rdata_valid & use_b;

    cache_line_transfer_fsm dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected & ~use_b),
        .miss_address     (miss_address[15:0]),
        .victim_dirty     (victim_dirty),
        .victim_address   (victim_address[15:0]),
        .fsm_busy         (busy_a),
        .mem              (ifa),
        .data_word_sel    (sel_a),
        .write_data_array (wda_a),
        .write_tag_array  (tag_a)
    );

    cache_line_transfer_fsm #(
        .ADDR_WIDTH(32), .WORD_BYTES(4), .WORDS_PER_LINE(4), .MAX_OUTSTANDING(2)
    ) dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected & use_b),
        .miss_address     (miss_address),
        .victim_dirty     (victim_dirty),
        .victim_address   (victim_address),
        .fsm_busy         (busy_b),
        .mem              (ifb),
        .data_word_sel    (sel_b),
        .write_data_array (wda_b),
        .write_tag_array  (tag_b)
    );

    // View of whichever instance is currently under test
    logic        v_valid, v_write, v_busy, v_wda, v_tag;
    logic [31:0] v_addr;
    logic [2:0]  v_sel;
    assign v_valid = use_b ? ifb.mem_req_valid : ifa.mem_req_valid;
    assign v_write = use_b ? ifb.mem_req_write : ifa.mem_req_write;
    assign v_addr  = use_b ? ifb.mem_req_addr  : {16'h0, ifa.mem_req_addr};
    assign v_sel   = use_b ? {1'b0, sel_b}     : sel_a;
    assign v_busy  = use_b ? busy_b : busy_a;
    assign v_wda   = use_b ? wda_b  : wda_a;
    assign v_tag   = use_b ? tag_b  : tag_a;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  sel;
    } req_t;

    typedef struct packed {
        logic [2:0] sel;
        logic       tag;
    } dw_t;

    req_t exp_req[$];
    dw_t  exp_dw[$];
    int   pending[$];

    int words = 8, wbytes = 2, max_out = 4;
    int cyc = 0, tb_out = 0, ret_count = 0;
    int ret_delay = 1, stall_from = -100;
    bit rand_ready = 1'b0, rand_delay = 1'b0, junk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: whole victim line written word by word, then whole fill line read.
    task automatic push_expect(input logic [31:0] a, input logic d, input logic [31:0] v);
        int lb;
        logic [31:0] fb, vb;
        lb = words * wbytes;
        fb = a - (a % lb);
        vb = v - (v % lb);
        if (d) for (int i = 0; i < words; i++)
            exp_req.push_back('{wr: 1'b1, addr: vb + 32'(i * wbytes), sel: 3'(i)});
        for (int i = 0; i < words; i++)
            exp_req.push_back('{wr: 1'b0, addr: fb + 32'(i * wbytes), sel: 3'(0)});
        for (int i = 0; i < words; i++)
            exp_dw.push_back('{sel: 3'(i), tag: (i == words - 1)});
    endtask

    // Memory model: ready pattern and in-order delayed read returns
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        ready = rand_ready ? 1'($urandom % 2) : 1'b1;
        if (cyc >= stall_from && cyc < stall_from + 3) ready = 1'b0;
        rdata_valid = 1'b0;
        if (pending.size() > 0 && pending[0] <= cyc) begin
            void'(pending.pop_front());
            rdata_valid = 1'b1;
        end
    end

    // Monitor: every check here describes the transfer at the coming rising edge
    logic        prev_stall = 1'b0, prev_wr = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [2:0]  prev_sel   = '0;
    initial begin
        req_t e;
        dw_t  d;
        bit   acc_read;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                acc_read = 1'b0;
                if (prev_stall) begin
                    check("stall_valid_held", 32'(v_valid), 32'd1);
                    check("stall_addr_held", v_addr, prev_addr);
                    if (prev_wr) check("stall_sel_held", 32'(v_sel), 32'(prev_sel));
                end
                prev_stall = v_valid && !ready;
                prev_addr  = v_addr;
                prev_wr    = v_write;
                prev_sel   = v_sel;
                if (v_valid && !v_write) check("outstanding_limit", 32'(tb_out < max_out), 32'd1);
                if (v_valid && ready) begin
                    if (exp_req.size() == 0) begin
                        check("unexpected_request", v_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_req.pop_front();
                        check("req_write", 32'(v_write), 32'(e.wr));
                        check("req_addr", v_addr, e.addr);
                        if (e.wr) check("wb_sel", 32'(v_sel), 32'(e.sel));
                        if (!v_write) begin
                            acc_read = 1'b1;
                            pending.push_back(cyc + (rand_delay ? int'($urandom_range(1, 6)) : ret_delay));
                        end
                    end
                end
                if (rdata_valid) begin
                    check("rdata_protocol", 32'(tb_out > 0), 32'd1);
                    if (exp_dw.size() == 0) begin
                        check("unexpected_return", 32'(v_sel), 32'hFFFF_FFFF);
                    end else begin
                        d = exp_dw.pop_front();
                        check("data_write", 32'(v_wda), 32'd1);
                        check("data_sel", 32'(v_sel), 32'(d.sel));
                        check("tag_write", 32'(v_tag), 32'(d.tag));
                    end
                    ret_count++;
                    tb_out--;
                end else if (v_wda || v_tag) begin
                    check("spurious_array_write", {30'd0, v_wda, v_tag}, 32'd0);
                end
                if (acc_read) tb_out++;
            end
        end
    end

    task automatic do_miss(input logic [31:0] a, input logic d, input logic [31:0] v);
        check("idle_before_miss", 32'(v_busy), 32'd0);
        miss_address   = a;
        victim_dirty   = d;
        victim_address = v;
        miss_detected  = 1'b1;
        push_expect(a, d, v);
        @(posedge clk);
        #2;
        miss_detected  = 1'b0;
        miss_address   = $urandom;
        victim_address = $urandom;
        check("busy_after_miss", 32'(v_busy), 32'd1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        forever begin
            @(posedge clk);
            #2;
            cycles++;
            if (junk_en && v_busy) begin
                miss_detected  = 1'($urandom % 2);
                miss_address   = $urandom;
                victim_address = $urandom;
                victim_dirty   = 1'($urandom % 2);
            end else begin
                miss_detected = 1'b0;
            end
            if (!v_busy && exp_req.size() == 0 && exp_dw.size() == 0) break;
            if (cycles > 3000) begin
                check("done_timeout", 32'(cycles), 32'd0);
                break;
            end
        end
        check("outstanding_after_done", 32'(tb_out), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(v_valid), 32'd0);
        check({tag, "_write"}, 32'(v_write), 32'd0);
        check({tag, "_addr"},  v_addr,        32'd0);
        check({tag, "_sel"},   32'(v_sel),   32'd0);
        check({tag, "_wda"},   32'(v_wda),   32'd0);
        check({tag, "_tag"},   32'(v_tag),   32'd0);
        check({tag, "_busy"},  32'(v_busy),  32'd0);
    endtask

    initial begin
        int cyc_cnt, base, n;
        #12;
        check_outputs_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // clean fill, ready=1, 1-cycle return
        do_miss(32'h1234, 1'b0, 32'h0);
        wait_done(cyc_cnt);
        check("clean_fill_latency", 32'(cyc_cnt), 32'(words + 1));

        // dirty victim write-back then fill
        do_miss(32'h5678, 1'b1, 32'hABC6);
        wait_done(cyc_cnt);

        // 3-cycle backpressure inside the eviction, then inside a fill
        stall_from = cyc + 3;
        do_miss(32'h2222, 1'b1, 32'h9A0E);
        wait_done(cyc_cnt);
        stall_from = cyc + 4;
        ret_delay  = 2;
        do_miss(32'h3C01, 1'b0, 32'h0);
        wait_done(cyc_cnt);

        // randomized misses with random ready, delays and ignored misses while busy
        rand_ready = 1'b1;
        rand_delay = 1'b1;
        junk_en    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            do_miss({16'h0, 16'($urandom)}, 1'($urandom % 2), {16'h0, 16'($urandom)});
            wait_done(cyc_cnt);
        end
        rand_ready = 1'b0;
        rand_delay = 1'b0;
        junk_en    = 1'b0;
        ret_delay  = 1;

        // asynchronous reset after three fill returns
        do_miss(32'h7770, 1'b0, 32'h0);
        base = ret_count;
        n    = 0;
        while (ret_count < base + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("returns_before_abort", 32'(ret_count - base), 32'd3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_req.delete();
        exp_dw.delete();
        pending.delete();
        tb_out = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        do_miss(32'h4442, 1'b0, 32'h0);
        wait_done(cyc_cnt);
        check("post_abort_latency", 32'(cyc_cnt), 32'(words + 1));

        // reparameterised instance: 32-bit address, 4-byte words, 4-word line, 2 outstanding
        use_b   = 1'b1;
        words   = 4;
        wbytes  = 4;
        max_out = 2;
        ret_delay = 5;
        @(posedge clk);
        #2;
        do_miss(32'h0000_1F3C, 1'b0, 32'h0);
        wait_done(cyc_cnt);
        do_miss(32'h00C0_0104, 1'b1, 32'hFFFF_FFF7);
        wait_done(cyc_cnt);
        rand_ready = 1'b1;
        rand_delay = 1'b1;
        junk_en    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_miss($urandom, 1'($urandom % 2), $urandom);
            wait_done(cyc_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
